// File: rtl/period_stats.sv
// period_stats
//   Downstream stage of the monitor period counter. It samples the counter's
//   held result once per monitor toggle and collects blocks of 2^LOG2N
//   half-period samples. For each block it reports the truncated average, the
//   minimum and the maximum, with a one-cycle valid strobe. An idle watchdog
//   raises stall when the monitor has not toggled for 2^WIDTH-1 cycles.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   monitor_i  clk-synchronous monitor net (same net as the period counter)
//   count_i    counter's held half-period result, stable while strobe is high
//   avg_o      block average, truncated
//   min_o      smallest sample of the last block
//   max_o      largest sample of the last block
//   valid_o    one-cycle pulse when avg_o/min_o/max_o update
//   stall_o    level: monitor idle too long, statistics are stale
module period_stats #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             monitor_i,
  input  logic [WIDTH-1:0] count_i,
  output logic [WIDTH-1:0] avg_o,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o,
  output logic             valid_o,
  output logic             stall_o
);

  localparam int ACC_W = WIDTH + LOG2N;

  localparam logic ST_DISCARD = 1'b0;
  localparam logic ST_ACC     = 1'b1;

  localparam logic [WIDTH-1:0] IDLE_MAX = {WIDTH{1'b1}};
  // One below terminal count: the edge leaving this value is where idle
  // would reach all ones, which is when stall must rise.
  localparam logic [WIDTH-1:0] IDLE_PRE = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [LOG2N-1:0] N_LAST   = {LOG2N{1'b1}};

  function automatic logic [WIDTH-1:0] smaller(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] larger(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic             m1_q, m2_q;
  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] minr_q, minr_d;
  logic [WIDTH-1:0] maxr_q, maxr_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [WIDTH-1:0] idle_q, idle_d;
  logic [WIDTH-1:0] avg_q, avg_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;

  logic             strobe;
  logic [ACC_W-1:0] sum;
  logic [WIDTH-1:0] min_new, max_new;

  // The counter updates count_i on the same edge that loads m1, so count_i
  // is already the finished half-period whenever strobe is high.
  assign strobe  = m1_q ^ m2_q;
  assign sum     = acc_q + ACC_W'(count_i);
  assign min_new = smaller(minr_q, count_i);
  assign max_new = larger(maxr_q, count_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    minr_d  = minr_q;
    maxr_d  = maxr_q;
    n_d     = n_q;
    avg_d   = avg_q;
    min_d   = min_q;
    max_d   = max_q;
    valid_d = 1'b0;
    stall_d = stall_q;

    if (strobe)                 idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    else                        idle_d = idle_q;

    if (strobe) begin
      if (state_q == ST_DISCARD) begin
        // First toggle after reset or stall ends a partial period: drop it.
        state_d = ST_ACC;
        stall_d = 1'b0;
      end else if (n_q == N_LAST) begin
        avg_d   = sum[ACC_W-1:LOG2N];
        min_d   = min_new;
        max_d   = max_new;
        valid_d = 1'b1;
        acc_d   = '0;
        minr_d  = '1;
        maxr_d  = '0;
        n_d     = '0;
      end else begin
        acc_d   = sum;
        minr_d  = min_new;
        maxr_d  = max_new;
        n_d     = n_q + 1'b1;
      end
    end else if (idle_q == IDLE_PRE) begin
      // Watchdog expiry; a coincident strobe takes the branch above instead.
      stall_d = 1'b1;
      state_d = ST_DISCARD;
      acc_d   = '0;
      minr_d  = '1;
      maxr_d  = '0;
      n_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m1_q    <= 1'b0;
      m2_q    <= 1'b0;
      state_q <= ST_DISCARD;
      acc_q   <= '0;
      minr_q  <= '1;
      maxr_q  <= '0;
      n_q     <= '0;
      idle_q  <= '0;
      avg_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      m1_q    <= monitor_i;
      m2_q    <= m1_q;
      state_q <= state_d;
      acc_q   <= acc_d;
      minr_q  <= minr_d;
      maxr_q  <= maxr_d;
      n_q     <= n_d;
      idle_q  <= idle_d;
      avg_q   <= avg_d;
      min_q   <= min_d;
      max_q   <= max_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
    end
  end

  assign avg_o   = avg_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign valid_o = valid_q;
  assign stall_o = stall_q;

endmodule

// File: doc/period_stats.md
# period_stats

Downstream stage of the monitor period counter. Watches the same `monitor` net and samples the counter's held `count` result once per monitor toggle. Over blocks of 2^LOG2N half-periods it produces average, minimum and maximum half-period length, plus a one-cycle `valid` strobe. It also flags a stalled monitor (no toggle for 2^WIDTH−1 cycles) so the scope UI can show "no signal" instead of stale numbers.

## Interface
- `WIDTH`, 16, width of `count` and of all result outputs.
- `LOG2N`, 3, log2 of samples per block (N = 2^LOG2N); 1..8 legal.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `monitor`  in  1  same clk-synchronous net that drives the period counter.
- `count`  in  WIDTH  counter's held result; updates on the edge at which the counter sees a monitor change.
- `avg`  out  WIDTH  block average, truncated.
- `min`  out  WIDTH  smallest sample in block.
- `max`  out  WIDTH  largest sample in block.
- `valid`  out  1  one-cycle pulse: avg/min/max just updated.
- `stall`  out  1  level: monitor idle too long; statistics invalid.

## Operation
- Toggle detect:
  - `m1 <= monitor`, `m2 <= m1`; `strobe = m1 ^ m2`.
  - The counter's `out` updates on the same edge that loads the new value into `m1`, so `count` is already stable when `strobe` is high.
- States:
  - DISCARD (reset state):
    - First strobe after reset or after stall is a partial period and is dropped.
    - On that strobe: go to ACC, clear `stall`.
  - ACC: on each strobe, the sample is `count`.
    - `acc <= acc + count`, `minr <= min(minr, count)`, `maxr <= max(maxr, count)`, `n <= n + 1`.
    - `acc` is WIDTH+LOG2N bits and never overflows.
- Block completion, when a strobe arrives with `n == N−1`. On that edge, with the current sample included:
  - `avg <= (acc + count) >> LOG2N`; `min`, `max` likewise include the current sample.
  - `valid <= 1`.
  - `acc <= 0`, `minr <= all ones`, `maxr <= 0`, `n <= 0`; stay in ACC.
- Output hold: avg/min/max hold between blocks and hold through stall.
- Idle watchdog:
  - WIDTH-bit `idle` counter; cleared on strobe, else increments.
  - When `idle` reaches all ones with no strobe:
    - `stall <= 1`, state to DISCARD.
    - `acc`, `minr`, `maxr` and `n` are reinitialised; the partial block is dropped and no `valid` is issued.
    - `idle` saturates; it does not wrap.
- Simultaneous strobe and watchdog terminal count: strobe wins, and no stall occurs.
- Zero-valued samples are legal (toggle every cycle); handled normally.
- Reset values: `avg`, `min`, `max` = 0; `valid` = 0; `stall` = 0.
- Reset values, internal: state DISCARD, `n` = 0, `acc` = 0, `minr` = all ones, `maxr` = 0, `idle` = 0, `m1` = `m2` = 0.
- Reset mid-block: all state returns to reset values on the next edge. The partial block is lost, and the next strobe is discarded.

## Timing
- Monitor change sampled at edge k → `m1` changes at k → strobe high during cycle k..k+1 → sample captured at edge k+1.
- For the completing sample: `avg`/`min`/`max`/`valid` registered at edge k+1.
- `valid` is high for exactly the one cycle after k+1, then low at k+2 unless another block completes.
- Throughput: one sample per clock max (monitor toggling every cycle); no back-pressure.
- `stall` rises on the edge at which `idle` hits all ones, i.e. 2^WIDTH−1 idle cycles after the last strobe.
- `stall` falls on the edge that consumes the next (discarded) strobe.

## Test plan
- WIDTH=8, LOG2N=2. After reset, toggle monitor with count = 7 (discarded), then 10, 12, 14, 16 → single `valid` pulse, avg=13, min=10, max=16. `valid` occurs exactly 1 edge after the 4th accepted strobe.
- Truncation and back-to-back blocks: samples 10, 10, 10, 11 then 255, 255, 255, 255 → first avg=10, min=10, max=11; second avg=255, min=max=255. Outputs hold between pulses.
- Toggle every clock with count=0: after the discard, `valid` every 4th cycle with avg=min=max=0; no stall.
- Stall:
  - Stop toggling after 2 accepted samples → `stall`=1 exactly 255 cycles after the last strobe, no `valid`, outputs hold the previous block.
  - Resume: the first strobe is discarded and `stall` clears; the next 4 samples form a clean block.
- Terminal-count tie: strobe arrives on the cycle `idle` reaches 255 → no stall; sample accepted.
- Assert `rst` one cycle after 3 accepted samples → all outputs 0 next edge. The next strobe is discarded, and a full 4 new samples are required before `valid`.
